// File: rtl/bitrev_frame_sequencer.sv
// bitrev_frame_sequencer
// Streaming front end for the FFT input reorder. Samples arrive in natural
// order over a valid/ready handshake and are collected into frames of
// SAMPLES entries. A complete frame is then emitted in bit-reversed index
// order over a second valid/ready handshake.
//
// Build option: define BITREV_PINGPONG_EN for two ping-pong banks, so one
// frame can fill while the other drains. Without it there is a single bank,
// and fill and drain strictly alternate.
module bitrev_frame_sequencer #(
   parameter  int SAMPLES = 4,
   parameter  int WIDTH   = 4,
   localparam int IDXW    = $clog2(SAMPLES)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [IDXW-1:0]  out_index,
   output logic             out_last,
   output logic             frame_done
);

`ifdef BITREV_PINGPONG_EN
   localparam int NB = 2;
   localparam int AW = IDXW + 1;
`else
   localparam int NB = 1;
   localparam int AW = IDXW;
`endif

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } bankState_t;

   bankState_t       r_bankState     [NB];
   bankState_t       w_bankStateNext [NB];
   logic [WIDTH-1:0] r_mem [NB*SAMPLES];
   logic [IDXW-1:0]  r_wrCnt;
   logic [IDXW-1:0]  r_rdCnt;
   logic             r_frameDone;

   logic             w_wrFull;
   logic             w_rdFull;
   logic             w_inAccept;
   logic             w_outHs;
   logic             w_wrLast;
   logic             w_rdLast;
   logic [NB-1:0]    w_wrSel;
   logic [NB-1:0]    w_rdSel;
   logic [AW-1:0]    w_wrAddr;
   logic [AW-1:0]    w_rdAddr;

   // Reverses the order of all IDXW index bits.
   function automatic logic [IDXW-1:0] bitRev(input logic [IDXW-1:0] v);
      logic [IDXW-1:0] res;
      for (int i = 0; i < IDXW; i++) begin
         res[i] = v[IDXW-1-i];
      end
      return res;
   endfunction

`ifdef BITREV_PINGPONG_EN
   logic r_wrBank;
   logic r_rdBank;

   assign w_wrSel  = r_wrBank ? 2'b10 : 2'b01;
   assign w_rdSel  = r_rdBank ? 2'b10 : 2'b01;
   assign w_wrFull = (r_bankState[r_wrBank] == FULL);
   assign w_rdFull = (r_bankState[r_rdBank] == FULL);
   assign w_wrAddr = {r_wrBank, r_wrCnt};
   assign w_rdAddr = {r_rdBank, bitRev(r_rdCnt)};

   // Bank pointers advance to the other bank once their current frame is
   // completely written or completely read.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wrBank <= 1'b0;
         r_rdBank <= 1'b0;
      end else begin
         if (w_inAccept && w_wrLast) begin
            r_wrBank <= ~r_wrBank;
         end
         if (w_outHs && w_rdLast) begin
            r_rdBank <= ~r_rdBank;
         end
      end
   end
`else
   assign w_wrSel  = 1'b1;
   assign w_rdSel  = 1'b1;
   assign w_wrFull = (r_bankState[0] == FULL);
   assign w_rdFull = (r_bankState[0] == FULL);
   assign w_wrAddr = r_wrCnt;
   assign w_rdAddr = bitRev(r_rdCnt);
`endif

   assign w_wrLast   = (r_wrCnt == IDXW'(SAMPLES - 1));
   assign w_rdLast   = (r_rdCnt == IDXW'(SAMPLES - 1));
   assign w_inAccept = in_valid && !w_wrFull;
   assign w_outHs    = w_rdFull && out_ready;

   assign in_ready   = !w_wrFull;
   assign out_valid  = w_rdFull;
   assign out_index  = r_rdCnt;
   assign out_last   = w_rdFull && w_rdLast;
   assign out_data   = r_mem[w_rdAddr];
   assign frame_done = r_frameDone;

   // Per-bank next state: a bank becomes FULL on its last write and goes back
   // to EMPTY on its last read. A bank is written only while EMPTY, so the
   // two transitions never compete for the same bank.
   always_comb begin
      for (int b = 0; b < NB; b++) begin
         w_bankStateNext[b] = r_bankState[b];
         case (r_bankState[b])
            EMPTY: begin
               if (w_wrSel[b] && w_inAccept && w_wrLast) begin
                  w_bankStateNext[b] = FULL;
               end
            end
            FULL: begin
               if (w_rdSel[b] && w_outHs && w_rdLast) begin
                  w_bankStateNext[b] = EMPTY;
               end
            end
            default: begin
               w_bankStateNext[b] = EMPTY;
            end
         endcase
      end
   end

   // Bank state register. Reset discards any partial or pending frame.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int b = 0; b < NB; b++) begin
            r_bankState[b] <= EMPTY;
         end
      end else begin
         for (int b = 0; b < NB; b++) begin
            r_bankState[b] <= w_bankStateNext[b];
         end
      end
   end

   // Write and read slot counters, each wrapping at the end of a frame.
   // frame_done pulses for the cycle after the last read handshake.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wrCnt     <= '0;
         r_rdCnt     <= '0;
         r_frameDone <= 1'b0;
      end else begin
         if (w_inAccept) begin
            r_wrCnt <= w_wrLast ? '0 : r_wrCnt + 1'b1;
         end
         if (w_outHs) begin
            r_rdCnt <= w_rdLast ? '0 : r_rdCnt + 1'b1;
         end
         r_frameDone <= w_outHs && w_rdLast;
      end
   end

   // Sample storage is deliberately left unreset. Contents are only observed
   // once a full frame has been written into the bank.
   always_ff @(posedge clk) begin
      if (w_inAccept) begin
         r_mem[w_wrAddr] <= in_data;
      end
   end

endmodule

// File: tb/tb_bitrev_frame_sequencer.sv
// tb_bitrev_frame_sequencer
// Directed bench for bitrev_frame_sequencer. It uses a SAMPLES=4 instance
// for the main sequences and a SAMPLES=8 instance for the wider reorder.
// If BITREV_PINGPONG_EN is defined, the full-bank stall sequence is replaced
// by a three-frame streaming sequence.
module tb_bitrev_frame_sequencer;

`ifdef BITREV_PINGPONG_EN
   localparam logic DRAIN_READY = 1'b1;
`else
   localparam logic DRAIN_READY = 1'b0;
`endif

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_data;
   logic [1:0] out_index;
   logic       out_last;
   logic       frame_done;

   logic       in_valid8;
   logic       in_ready8;
   logic [3:0] in_data8;
   logic       out_valid8;
   logic       out_ready8;
   logic [3:0] out_data8;
   logic [2:0] out_index8;
   logic       out_last8;
   logic       frame_done8;

   int passCount;
   int checkCount;

   logic [3:0] expA [4];
   logic [3:0] expB [4];
   logic [3:0] expC [4];
   logic [3:0] exp8 [8];

   bitrev_frame_sequencer #(.SAMPLES(4), .WIDTH(4)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_index  (out_index),
      .out_last   (out_last),
      .frame_done (frame_done)
   );

   bitrev_frame_sequencer #(.SAMPLES(8), .WIDTH(4)) u_dut8 (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid8),
      .in_ready   (in_ready8),
      .in_data    (in_data8),
      .out_valid  (out_valid8),
      .out_ready  (out_ready8),
      .out_data   (out_data8),
      .out_index  (out_index8),
      .out_last   (out_last8),
      .frame_done (frame_done8)
   );

   // 10 ns free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one clock and settle just past the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic valid, input logic [3:0] data);
      in_valid = valid;
      in_data  = data;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
   endtask

   // Feed four samples on consecutive cycles, each expected to be accepted.
   task automatic feedFrame(input logic [3:0] d0, input logic [3:0] d1,
                            input logic [3:0] d2, input logic [3:0] d3, input string tag);
      logic [3:0] vals [4];
      vals[0] = d0; vals[1] = d1; vals[2] = d2; vals[3] = d3;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, vals[i]);
         checkOutput($sformatf("%s_inReady%0d", tag, i), 32'(in_ready), 32'd1);
         checkOutput($sformatf("%s_outValidFill%0d", tag, i), 32'(out_valid), 32'd0);
         step();
      end
      applyStimulus(1'b0, 4'h0);
   endtask

   // Drain one frame. Optionally hold out_ready low at slot stallAt for
   // stallCycles cycles. Ends on the cycle after the last handshake.
   task automatic drainFrame(input logic [3:0] exp [4], input int stallAt,
                             input int stallCycles, input string tag);
      for (int i = 0; i < 4; i++) begin
         if (i == stallAt) begin
            out_ready = 1'b0;
            for (int s = 0; s < stallCycles; s++) begin
               checkOutput($sformatf("%s_stallValid%0d", tag, s), 32'(out_valid), 32'd1);
               checkOutput($sformatf("%s_stallIndex%0d", tag, s), 32'(out_index), 32'(i));
               checkOutput($sformatf("%s_stallData%0d", tag, s), 32'(out_data), 32'(exp[i]));
               checkOutput($sformatf("%s_stallLast%0d", tag, s), 32'(out_last), 32'(i == 3));
               step();
            end
         end
         out_ready = 1'b1;
         checkOutput($sformatf("%s_valid%0d", tag, i), 32'(out_valid), 32'd1);
         checkOutput($sformatf("%s_index%0d", tag, i), 32'(out_index), 32'(i));
         checkOutput($sformatf("%s_data%0d", tag, i), 32'(out_data), 32'(exp[i]));
         checkOutput($sformatf("%s_last%0d", tag, i), 32'(out_last), 32'(i == 3));
         checkOutput($sformatf("%s_drainReady%0d", tag, i), 32'(in_ready), 32'(DRAIN_READY));
         checkOutput($sformatf("%s_doneLow%0d", tag, i), 32'(frame_done), 32'd0);
         step();
      end
      checkOutput($sformatf("%s_frameDone", tag), 32'(frame_done), 32'd1);
      checkOutput($sformatf("%s_validAfter", tag), 32'(out_valid), 32'd0);
      checkOutput($sformatf("%s_readyAfter", tag), 32'(in_ready), 32'd1);
   endtask

   // Directed sequence for both instances.
   initial begin
      passCount  = 0;
      checkCount = 0;
      rst_n      = 1'b0;
      out_ready  = 1'b0;
      in_valid8  = 1'b0;
      in_data8   = 4'h0;
      out_ready8 = 1'b0;
      applyStimulus(1'b0, 4'h0);
      expA[0] = 4'd6; expA[1] = 4'd0; expA[2] = 4'd2;  expA[3] = 4'd7;
      expB[0] = 4'd1; expB[1] = 4'd5; expB[2] = 4'd3;  expB[3] = 4'd9;
      expC[0] = 4'd4; expC[1] = 4'd12; expC[2] = 4'd8; expC[3] = 4'd15;
      exp8[0] = 4'd0; exp8[1] = 4'd4; exp8[2] = 4'd2; exp8[3] = 4'd6;
      exp8[4] = 4'd1; exp8[5] = 4'd5; exp8[6] = 4'd3; exp8[7] = 4'd7;
      step();
      step();
      rst_n = 1'b1;

      // Reset state.
      checkOutput("rst_inReady",   32'(in_ready),   32'd1);
      checkOutput("rst_outValid",  32'(out_valid),  32'd0);
      checkOutput("rst_outLast",   32'(out_last),   32'd0);
      checkOutput("rst_outIndex",  32'(out_index),  32'd0);
      checkOutput("rst_frameDone", 32'(frame_done), 32'd0);

      // Basic reorder: 6,2,0,7 -> 6,0,2,7.
      out_ready = 1'b1;
      feedFrame(4'd6, 4'd2, 4'd0, 4'd7, "basic");
      drainFrame(expA, -1, 0, "basic");
      step();
      checkOutput("basic_donePulseEnd", 32'(frame_done), 32'd0);

      // Backpressure at slot 1 for three cycles.
      feedFrame(4'd6, 4'd2, 4'd0, 4'd7, "bp");
      drainFrame(expA, 1, 3, "bp");
      step();

`ifdef BITREV_PINGPONG_EN
      // Three frames back-to-back at full rate with out_ready held high.
      out_ready = 1'b1;
      for (int t = 0; t < 16; t++) begin
         if (t < 12) begin
            applyStimulus(1'b1, 4'(t + 1));
            checkOutput($sformatf("pp_inReady%0d", t), 32'(in_ready), 32'd1);
         end else begin
            applyStimulus(1'b0, 4'h0);
         end
         if (t >= 4) begin
            checkOutput($sformatf("pp_valid%0d", t), 32'(out_valid), 32'd1);
            checkOutput($sformatf("pp_index%0d", t), 32'(out_index), 32'((t - 4) % 4));
            checkOutput($sformatf("pp_data%0d", t), 32'(out_data),
                        32'(((t - 4) / 4) * 4 + ((((t - 4) % 4) & 1) << 1)
                            + ((((t - 4) % 4) >> 1) & 1) + 1));
         end else begin
            checkOutput($sformatf("pp_validFill%0d", t), 32'(out_valid), 32'd0);
         end
         step();
      end
      checkOutput("pp_frameDone", 32'(frame_done), 32'd1);
      checkOutput("pp_validEnd", 32'(out_valid), 32'd0);
      step();
`else
      // Gapped input for frame A, then frame B presented during the drain.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, (i == 0) ? 4'd6 : (i == 1) ? 4'd2 : (i == 2) ? 4'd0 : 4'd7);
         checkOutput($sformatf("gap_inReady%0d", i), 32'(in_ready), 32'd1);
         step();
         applyStimulus(1'b0, 4'hF);
         if (i < 3) begin
            checkOutput($sformatf("gap_noValid%0d", i), 32'(out_valid), 32'd0);
            step();
         end
      end
      applyStimulus(1'b1, 4'd1);
      drainFrame(expA, -1, 0, "stallA");
      step();
      checkOutput("stall_b1Taken", 32'(in_ready), 32'd1);
      applyStimulus(1'b0, 4'h0);
      step();
      applyStimulus(1'b1, 4'd3);
      step();
      applyStimulus(1'b1, 4'd5);
      step();
      applyStimulus(1'b0, 4'h0);
      step();
      applyStimulus(1'b1, 4'd9);
      checkOutput("stall_b9Ready", 32'(in_ready), 32'd1);
      step();
      applyStimulus(1'b0, 4'h0);
      drainFrame(expB, -1, 0, "stallB");
      step();
`endif

      // Reset after two of four samples, then a fresh frame.
      applyStimulus(1'b1, 4'd6);
      step();
      applyStimulus(1'b1, 4'd2);
      step();
      applyStimulus(1'b0, 4'h0);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      checkOutput("midRst_inReady",  32'(in_ready),  32'd1);
      checkOutput("midRst_outValid", 32'(out_valid), 32'd0);
      checkOutput("midRst_outIndex", 32'(out_index), 32'd0);
      feedFrame(4'd4, 4'd8, 4'd12, 4'd15, "midRst");
      drainFrame(expC, -1, 0, "midRst");
      step();

      // SAMPLES=8: 0..7 -> 0,4,2,6,1,5,3,7.
      out_ready8 = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_valid8 = 1'b1;
         in_data8  = 4'(i);
         checkOutput($sformatf("s8_inReady%0d", i), 32'(in_ready8), 32'd1);
         step();
      end
      in_valid8 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         checkOutput($sformatf("s8_valid%0d", i), 32'(out_valid8), 32'd1);
         checkOutput($sformatf("s8_index%0d", i), 32'(out_index8), 32'(i));
         checkOutput($sformatf("s8_data%0d", i), 32'(out_data8), 32'(exp8[i]));
         checkOutput($sformatf("s8_last%0d", i), 32'(out_last8), 32'(i == 7));
         step();
      end
      checkOutput("s8_frameDone", 32'(frame_done8), 32'd1);
      checkOutput("s8_validEnd", 32'(out_valid8), 32'd0);

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/bitrev_frame_sequencer.md
Name: bitrev_frame_sequencer

Overview:
- Sequential front-end controller for the FFT input-reordering path.
- Accepts a serial stream of samples over a valid/ready handshake and buffers them in frames of SAMPLES.
- Once a frame is complete, emits it serially in bit-reversed index order, over a second valid/ready handshake, to the FFT butterfly stage.
- Replaces the static all-parallel reorder for streaming sources such as the ADC/audio capture path.

Parameters:
- SAMPLES, 4, frame length; power of two, >= 2.
- WIDTH, 4, sample width in bits.
- IDXW, $clog2(SAMPLES), index width; derived, not overridden.

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a sample this cycle.
- in_data  input  WIDTH  input sample, natural order.
- out_valid  output  1  out_data/out_index are valid.
- out_ready  input  1  downstream accepts the output this cycle.
- out_data  output  WIDTH  sample at buffer position bitrev(out_index).
- out_index  output  IDXW  output slot number, 0..SAMPLES-1.
- out_last  output  1  high with the final slot (out_index == SAMPLES-1).
- frame_done  output  1  one-cycle pulse on the cycle after the last output handshake of a frame.

Behaviour:
- Storage: NB banks of SAMPLES x WIDTH registers.
  - NB = 1 by default; NB = 2 with PINGPONG_EN.
  - Each bank has a full flag.
- Write side:
  - wr_bank pointer, wr_cnt (IDXW bits).
  - in_ready = !full[wr_bank].
  - Accept = in_valid & in_ready: mem[wr_bank][wr_cnt] <= in_data, then wr_cnt++.
  - When wr_cnt == SAMPLES-1 on accept: full[wr_bank] <= 1, wr_cnt <= 0, wr_bank toggles (NB = 2 only).
- Read side:
  - rd_bank pointer, rd_cnt (IDXW bits).
  - out_valid = full[rd_bank]; out_index = rd_cnt; out_last = out_valid & (rd_cnt == SAMPLES-1).
  - out_data = mem[rd_bank][bitrev(rd_cnt)], combinational from the registered state, where bitrev reverses all IDXW bits.
  - Handshake = out_valid & out_ready: rd_cnt++.
  - On the handshake with out_last: full[rd_bank] <= 0, rd_cnt <= 0, rd_bank toggles (NB = 2 only), frame_done <= 1 for the next cycle.
- Per-bank state machine:
  - States: EMPTY (filling or idle) and FULL (draining).
  - EMPTY->FULL on the last input accept; FULL->EMPTY on the last output handshake.
- Latency:
  - out_valid rises the cycle after the last sample of a frame is accepted.
  - First-sample-in to first-sample-out = SAMPLES cycles at full input rate.
- Handshake rules:
  - While out_valid is high and out_ready is low, out_data, out_index and out_last hold stable.
  - in_ready never depends combinationally on in_valid.
  - out_valid never depends on out_ready.
- Partial frame: an in_valid gap mid-frame simply stalls. No timeout, no padding.
- Simultaneous last-write and last-read on the same bank cannot occur, because a bank is only written when EMPTY.
- NB = 1: in_ready is 0 for the whole drain. It rises the cycle after the last output handshake.
- Reset (any cycle, including mid-fill or mid-drain):
  - wr_cnt, rd_cnt, wr_bank, rd_bank and all full flags go to 0; frame_done goes to 0.
  - Partial frames are discarded. Sample memory is not reset.
  - Reset values: in_ready = 1, out_valid = 0, out_last = 0, out_index = 0, frame_done = 0.
  - out_data is don't-care while out_valid = 0.

Optional Feature:
- Macro: BITREV_PINGPONG_EN.
- Defined:
  - NB = 2 ping-pong banks.
  - Bank A can fill while bank B drains.
  - A sustained stream of one sample per cycle with out_ready held high flows with zero stalls after the first frame.
  - If both banks are FULL, in_ready = 0.
  - In the same cycle, the last input accept on one bank and the last output handshake on the other are both honoured.
- Undefined:
  - Single bank, NB = 1.
  - Fill and drain are strictly alternating.
  - wr_bank and rd_bank are constant 0 and are removed.

Test Plan:
- Basic reorder (SAMPLES=4, WIDTH=4): feed 6,2,0,7 back-to-back, out_ready=1 -> out_data 6,0,2,7 with out_index 0,1,2,3; out_last on the 4th; frame_done one cycle later; out_valid first high on the cycle after sample 7 is accepted.
- Backpressure: same frame, out_ready low for 3 cycles at out_index=1 -> out_data holds 0 and out_index holds 1; sequence otherwise unchanged; no sample lost or duplicated.
- Input gaps and full-bank stall (no macro): toggle in_valid every other cycle and present a 2nd frame during the drain -> in_ready = 0 until the cycle after the 1st frame's last handshake; 2nd frame 1,3,5,9 then emits 1,5,3,9.
- Reset mid-operation: assert rst_n=0 for 1 cycle after 2 of 4 samples -> in_ready = 1, out_valid = 0; a fresh frame 4,8,12,15 emits 4,12,8,15.
- Ping-pong throughput (BITREV_PINGPONG_EN): 3 frames streamed at one sample per cycle, out_ready=1 -> in_ready never drops; 12 outputs correct in bit-reversed order; out_valid continuous after the first frame.
- SAMPLES=8 sweep: input values 0..7 -> output order 0,4,2,6,1,5,3,7.
